// File: rtl/arm_defs_pkg.sv
// Shared EXE-stage definitions: datapath width, multiplier FSM encoding and
// the multiply opcode values the decoder uses to drive start/mla.
package arm_defs;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   // Multiply-class opcode field: the A bit selects accumulate.
   localparam logic [3:0] OPC_MUL = 4'b0000;
   localparam logic [3:0] OPC_MLA = 4'b0001;

endpackage

// File: rtl/exe_mul_unit_step.sv
// One shift-add iteration: adds the multiplicand, shifted by k, for every set
// bit k of the multiplier slice retired this cycle.
module mul_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic [WIDTH-1:0]          partial,
   input  logic [WIDTH-1:0]          multiplicand,
   input  logic [BITS_PER_CYCLE-1:0] multiplier_bits,
   output logic [WIDTH-1:0]          sum
);
   import arm_defs::*;

   always_comb begin
      sum = partial;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (multiplier_bits[k]) begin
            sum = sum + (multiplicand << k);
         end
      end
   end

endmodule

// File: rtl/exe_mul_unit.sv
// Iterative shift-add MUL/MLA unit for the EXE stage: retires BITS_PER_CYCLE
// multiplier bits per cycle and stalls the pipeline through busy meanwhile.
module exe_mul_unit #(
   parameter int WIDTH          = arm_defs::WIDTH,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic             mla,
   input  logic             s_bit,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] acc_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flags_we
);
   import arm_defs::*;

   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   mul_state_e       state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] step_sum;
   logic             s_bit_q;
   logic             start_ok;

   // flush always beats a simultaneous start
   assign start_ok = start & ~flush;

   mul_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .partial         (partial),
      .multiplicand    (mcand),
      .multiplier_bits (mplier[BITS_PER_CYCLE-1:0]),
      .sum             (step_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = RUN;
         end
         RUN: begin
            if (flush)              state_nxt = IDLE;
            else if (count == '0)   state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // done in DONE is already committed, so flush there cannot suppress it
   always_comb begin
      busy     = ((state == IDLE) & start_ok) | (state == RUN);
      done     = (state == DONE);
      flags_we = (state == DONE) & s_bit_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         mcand   <= '0;
         mplier  <= '0;
         partial <= '0;
         s_bit_q <= 1'b0;
         result  <= '0;
         flag_n  <= 1'b0;
         flag_z  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  mcand   <= op_a;
                  mplier  <= op_b;
                  partial <= mla ? acc_in : '0;
                  s_bit_q <= s_bit;
                  count   <= CNT_W'(STEPS - 1);
               end
            end
            RUN: begin
               if (!flush) begin
                  partial <= step_sum;
                  mcand   <= mcand << BITS_PER_CYCLE;
                  mplier  <= mplier >> BITS_PER_CYCLE;
                  if (count != '0) begin
                     count <= count - CNT_W'(1);
                  end else begin
                     result <= step_sum;
                     flag_n <= step_sum[WIDTH-1];
                     flag_z <= (step_sum == '0);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
